// File: rtl/seg_scan_decoder_if.sv
// Bundle for the scanned seven-segment bus and the decoded time frame.
// The display side or bench drives the bus as master. The decoder is the slave.
interface seg_scan_decoder_if;
    logic [7:0] seg;
    logic [7:0] an;
    logic [3:0] ones_min;
    logic [3:0] tens_min;
    logic [3:0] ones_hour;
    logic [3:0] tens_hour;
    logic [3:0] dp_mask;
    logic       frame_valid;
    logic       frame_changed;
    logic       decode_err;
    logic       stale;

    modport master (
        output seg, an,
        input  ones_min, tens_min, ones_hour, tens_hour, dp_mask,
        input  frame_valid, frame_changed, decode_err, stale
    );

    modport slave (
        input  seg, an,
        output ones_min, tens_min, ones_hour, tens_hour, dp_mask,
        output frame_valid, frame_changed, decode_err, stale
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Loopback decoder that turns the multiplexed seven-segment scan back into an HH:MM frame.
// Each digit is accepted only after it has been steady for STABLE_CYCLES samples.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 64,
    parameter int FRAME_TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_decoder_if.slave bus
);
    localparam int DW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(STABLE_CYCLES);
    localparam logic [DW-1:0] DWELL_ONE = DW'(1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(FRAME_TIMEOUT);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);

    // Returns {illegal, digit}. An all-dark pattern is a blank digit (4'hF).
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h40:   res = {1'b0, 4'h0};
            7'h79:   res = {1'b0, 4'h1};
            7'h24:   res = {1'b0, 4'h2};
            7'h30:   res = {1'b0, 4'h3};
            7'h19:   res = {1'b0, 4'h4};
            7'h12:   res = {1'b0, 4'h5};
            7'h02:   res = {1'b0, 4'h6};
            7'h78:   res = {1'b0, 4'h7};
            7'h00:   res = {1'b0, 4'h8};
            7'h10:   res = {1'b0, 4'h9};
            7'h7F:   res = {1'b0, 4'hF};
            default: res = {1'b1, 4'hF};
        endcase
        return res;
    endfunction

    logic [15:0]   sample_r;
    logic [DW-1:0] dwell_r;
    logic          accept_r;
    logic [3:0]    seen_r;
    logic [15:0]   shadow_digit_r;
    logic [3:0]    shadow_dp_r;
    logic [15:0]   out_digit_r;
    logic [3:0]    out_dp_r;
    logic          frame_valid_r;
    logic          frame_changed_r;
    logic          decode_err_r;
    logic          stale_r;
    logic [TW-1:0] tmo_r;

    logic [15:0]   sample_in_s;
    logic [DW-1:0] dwell_next_s;
    logic          accept_next_s;
    logic [7:0]    seg_s;
    logic [7:0]    an_s;
    logic [3:0]    slot_oh_s;
    logic          slot_ok_s;
    logic [4:0]    dec_s;
    logic [15:0]   shadow_digit_next_s;
    logic [3:0]    shadow_dp_next_s;
    logic [3:0]    seen_next_s;
    logic          err_s;
    logic          frame_done_s;
    logic          frame_diff_s;
    logic [TW-1:0] tmo_next_s;

    assign sample_in_s = {bus.seg, bus.an};
    assign seg_s       = sample_r[15:8];
    assign an_s        = sample_r[7:0];
    assign slot_oh_s   = ~an_s[3:0];
    assign slot_ok_s   = (an_s[7:4] == 4'hF) && (slot_oh_s != 4'h0)
                         && ((slot_oh_s & (slot_oh_s - 4'h1)) == 4'h0);
    assign dec_s       = seg_decode(seg_s[6:0]);

    // Dwell counter and one-shot accept strobe for a steady sample.
    always_comb begin
        dwell_next_s = DWELL_ONE;
        if (sample_in_s != sample_r) begin
            dwell_next_s = DWELL_ONE;
        end else if (dwell_r == DWELL_MAX) begin
            dwell_next_s = DWELL_MAX;
        end else begin
            dwell_next_s = dwell_r + DWELL_ONE;
        end
        accept_next_s = (dwell_next_s == DWELL_MAX) && (dwell_r != DWELL_MAX);
    end

    // Classify the accepted sample and update the shadow frame.
    always_comb begin
        shadow_digit_next_s = shadow_digit_r;
        shadow_dp_next_s    = shadow_dp_r;
        seen_next_s         = seen_r;
        err_s               = 1'b0;
        if (!accept_r) begin
            seen_next_s = seen_r;
        end else if (an_s == 8'hFF) begin
            seen_next_s = seen_r;
        end else if (slot_ok_s && !dec_s[4]) begin
            for (int i = 0; i < 4; i++) begin
                if (slot_oh_s[i]) begin
                    shadow_digit_next_s[4*i +: 4] = dec_s[3:0];
                    shadow_dp_next_s[i]           = ~seg_s[7];
                end else begin
                    shadow_digit_next_s[4*i +: 4] = shadow_digit_r[4*i +: 4];
                    shadow_dp_next_s[i]           = shadow_dp_r[i];
                end
            end
            seen_next_s = seen_r | slot_oh_s;
        end else begin
            err_s       = 1'b1;
            seen_next_s = 4'h0;
        end
        frame_done_s = (seen_next_s == 4'hF);
        frame_diff_s = ({shadow_digit_next_s, shadow_dp_next_s} != {out_digit_r, out_dp_r});
    end

    // Timeout counter; a completing frame takes priority over saturation.
    always_comb begin
        tmo_next_s = tmo_r;
        if (frame_done_s) begin
            tmo_next_s = {TW{1'b0}};
        end else if (tmo_r == TMO_MAX) begin
            tmo_next_s = TMO_MAX;
        end else begin
            tmo_next_s = tmo_r + TMO_ONE;
        end
    end

    // All state, including the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_r        <= 16'hFFFF;
            dwell_r         <= {DW{1'b0}};
            accept_r        <= 1'b0;
            seen_r          <= 4'h0;
            shadow_digit_r  <= 16'h0000;
            shadow_dp_r     <= 4'h0;
            out_digit_r     <= 16'h0000;
            out_dp_r        <= 4'h0;
            frame_valid_r   <= 1'b0;
            frame_changed_r <= 1'b0;
            decode_err_r    <= 1'b0;
            stale_r         <= 1'b0;
            tmo_r           <= {TW{1'b0}};
        end else begin
            sample_r        <= sample_in_s;
            dwell_r         <= dwell_next_s;
            accept_r        <= accept_next_s;
            shadow_digit_r  <= shadow_digit_next_s;
            shadow_dp_r     <= shadow_dp_next_s;
            seen_r          <= frame_done_s ? 4'h0 : seen_next_s;
            frame_valid_r   <= frame_done_s;
            frame_changed_r <= frame_done_s && frame_diff_s;
            decode_err_r    <= err_s;
            tmo_r           <= tmo_next_s;
            stale_r         <= (tmo_next_s >= TMO_MAX);
            if (frame_done_s) begin
                out_digit_r <= shadow_digit_next_s;
                out_dp_r    <= shadow_dp_next_s;
            end
        end
    end

    assign bus.ones_min      = out_digit_r[3:0];
    assign bus.tens_min      = out_digit_r[7:4];
    assign bus.ones_hour     = out_digit_r[11:8];
    assign bus.tens_hour     = out_digit_r[15:12];
    assign bus.dp_mask       = out_dp_r;
    assign bus.frame_valid   = frame_valid_r;
    assign bus.frame_changed = frame_changed_r;
    assign bus.decode_err    = decode_err_r;
    assign bus.stale         = stale_r;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full scans plus hand sequences
// for latency, timeout, illegal patterns and reset in the middle of a scan.
module tb_seg_scan_decoder;
    localparam int STABLE = 64;
    localparam int TMO    = 1000;
    localparam int DIG    = 100;
    localparam int GAP    = 80;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   fv_cnt = 0;
    int   fc_cnt = 0;
    int   er_cnt = 0;

    always #5 clk = ~clk;

    seg_scan_decoder_if bus();

    seg_scan_decoder #(.STABLE_CYCLES(STABLE), .FRAME_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.frame_valid)   fv_cnt++;
        if (bus.frame_changed) fc_cnt++;
        if (bus.decode_err)    er_cnt++;
    end

    typedef struct {
        logic [15:0] digits;   // {tens_hour, ones_hour, tens_min, ones_min}
        logic [3:0]  dps;      // bit i = dp lit on an[i]
        bit          glitch;
        bit          changed;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [7:0] anode(input int s);
        logic [7:0] a;
        a = 8'hFF;
        a[s] = 1'b0;
        return a;
    endfunction

    task automatic hold(input logic [7:0] s, input logic [7:0] a, input int n);
        bus.seg = s;
        bus.an  = a;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int s, input logic [3:0] d, input bit dp);
        hold({~dp, enc(d)}, anode(s), DIG);
        hold(8'hFF, 8'hFF, GAP);
    endtask

    task automatic scan(input logic [15:0] digits, input logic [3:0] dps, input bit glitch);
        for (int s = 3; s >= 0; s--) begin
            if (glitch) hold(8'h00, anode(s), 10);
            digit(s, digits[4*s +: 4], dps[s]);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [15:0] digits, input logic [3:0] dps);
        chk({tag, "_tens_hour"}, bus.tens_hour, digits[15:12]);
        chk({tag, "_ones_hour"}, bus.ones_hour, digits[11:8]);
        chk({tag, "_tens_min"},  bus.tens_min,  digits[7:4]);
        chk({tag, "_ones_min"},  bus.ones_min,  digits[3:0]);
        chk({tag, "_dp_mask"},   bus.dp_mask,   dps);
    endtask

    initial begin
        int fv0, fc0, er0;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 1'b1};
        vecs[1] = '{16'h1234, 4'b0000, 1'b1, 1'b0};
        vecs[2] = '{16'h9805, 4'b0000, 1'b0, 1'b1};
        vecs[3] = '{16'hF760, 4'b0100, 1'b0, 1'b1};
        vecs[4] = '{16'hF760, 4'b0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 4'b1111, 1'b0, 1'b1};

        reset   = 1'b1;
        bus.seg = 8'hFF;
        bus.an  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk_frame("reset", 16'h0000, 4'h0);
        chk("reset_fv",    bus.frame_valid,   1'b0);
        chk("reset_fc",    bus.frame_changed, 1'b0);
        chk("reset_err",   bus.decode_err,    1'b0);
        chk("reset_stale", bus.stale,         1'b0);
        reset = 1'b0;
        hold(8'hFF, 8'hFF, GAP);

        // Table of complete scans.
        for (int v = 0; v < 6; v++) begin
            fv0 = fv_cnt; fc0 = fc_cnt; er0 = er_cnt;
            scan(vecs[v].digits, vecs[v].dps, vecs[v].glitch);
            chk_frame($sformatf("vec%0d", v), vecs[v].digits, vecs[v].dps);
            chk($sformatf("vec%0d_fv", v),    fv_cnt - fv0, 1);
            chk($sformatf("vec%0d_fc", v),    fc_cnt - fc0, {31'd0, vecs[v].changed});
            chk($sformatf("vec%0d_err", v),   er_cnt - er0, 0);
            chk($sformatf("vec%0d_stale", v), bus.stale, 1'b0);
        end

        // Accept latency, then the timeout with scanning stopped.
        for (int s = 3; s >= 1; s--) digit(s, 4'(s + 1), 1'b0);
        hold({1'b1, enc(4'h1)}, anode(0), STABLE);
        chk("lat_early_fv", bus.frame_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_fv",       bus.frame_valid,   1'b1);
        chk("lat_fc",       bus.frame_changed, 1'b1);
        chk("lat_ones_min", bus.ones_min,      4'h1);
        chk("lat_tens_hr",  bus.tens_hour,     4'h4);
        bus.seg = 8'hFF;
        bus.an  = 8'hFF;
        @(posedge clk); #1;
        chk("fv_one_cycle", bus.frame_valid, 1'b0);
        repeat (TMO - 2) @(posedge clk);
        #1;
        chk("stale_before", bus.stale, 1'b0);
        @(posedge clk); #1;
        chk("stale_rise", bus.stale, 1'b1);
        fv0 = fv_cnt; fc0 = fc_cnt;
        scan(16'h4321, 4'h0, 1'b0);
        chk("stale_clear",    bus.stale, 1'b0);
        chk("stale_frame_fv", fv_cnt - fv0, 1);
        chk("stale_frame_fc", fc_cnt - fc0, 0);

        // Illegal segment pattern discards the partial frame.
        fv0 = fv_cnt; fc0 = fc_cnt; er0 = er_cnt;
        digit(3, 4'h5, 1'b0);
        digit(2, 4'h5, 1'b0);
        hold(8'h55, 8'hFE, 100);
        chk("illegal_err", er_cnt - er0, 1);
        hold(8'hFF, 8'hFF, GAP);
        digit(1, 4'h5, 1'b0);
        digit(0, 4'h5, 1'b0);
        chk("illegal_no_frame", fv_cnt - fv0, 0);
        chk("illegal_kept_th",  bus.tens_hour, 4'h4);
        chk("illegal_one_err",  er_cnt - er0, 1);
        scan(16'h5555, 4'h0, 1'b0);
        chk_frame("after_err", 16'h5555, 4'h0);
        chk("after_err_fv", fv_cnt - fv0, 1);
        chk("after_err_fc", fc_cnt - fc0, 1);

        // Bad anode codes.
        er0 = er_cnt;
        hold({1'b1, enc(4'h1)}, 8'hFC, 100);
        chk("an_fc_err", er_cnt - er0, 1);
        hold(8'hFF, 8'hFF, GAP);
        hold({1'b1, enc(4'h1)}, 8'hEF, 100);
        chk("an_ef_err", er_cnt - er0, 2);
        hold(8'hFF, 8'hFF, GAP);

        // Reset in the middle of a scan.
        fv0 = fv_cnt;
        digit(3, 4'h1, 1'b0);
        hold({1'b1, enc(4'h2)}, anode(2), 30);
        chk("pre_reset_th", bus.tens_hour, 4'h5);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_frame("mid_reset", 16'h0000, 4'h0);
        chk("mid_reset_stale", bus.stale, 1'b0);
        chk("mid_reset_fv",    bus.frame_valid, 1'b0);
        reset = 1'b0;
        hold(8'hFF, 8'hFF, GAP);
        digit(1, 4'h3, 1'b0);
        digit(0, 4'h4, 1'b0);
        chk("reset_partial_fv", fv_cnt - fv0, 0);
        chk("reset_partial_om", bus.ones_min, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
